// File: rtl/ysyx_22040175_mem_arbiter.sv
// Memory-bus arbiter between IF fetch and MEM load/store, one outstanding transaction.
// MEM wins by default; IF wins after STARVE_LIMIT consecutive losses.
module ysyx_22040175_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_inst,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic [63:0] mem_addr,
    input  logic        mem_wen,
    input  logic [63:0] mem_wdata,
    input  logic [7:0]  mem_wmask,
    output logic        mem_rsp_valid,
    output logic [63:0] mem_rsp_rdata,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [63:0] bus_addr,
    output logic        bus_wen,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wmask,
    input  logic        bus_rsp_valid,
    input  logic [63:0] bus_rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 32;
    localparam int unsigned MW = 8;
    localparam int unsigned SW = 4;
    localparam int unsigned TW = 8;
    localparam int unsigned STARVE_MAX = (1 << SW) - 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } bus_req_t;

    state_t        state_q, state_d;
    bus_req_t      req_q, req_d;
    logic          owner_mem_q, owner_mem_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          discard_q, discard_d;
    logic          bus_req_valid_q, busy_q;
    logic          if_rsp_valid_q, if_rsp_valid_d;
    logic [IW-1:0] if_rsp_inst_q, if_rsp_inst_d;
    logic          mem_rsp_valid_q, mem_rsp_valid_d;
    logic [DW-1:0] mem_rsp_rdata_q, mem_rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic grant_mem, grant_if, flush_hit, drop_if;

    // Fixed MEM priority, overridden once IF has lost STARVE_LIMIT times in a row
    always_comb begin
        grant_mem = mem_req_valid & ~(if_req_valid & (starve_q >= SW'(STARVE_LIMIT)));
        grant_if  = if_req_valid & ~grant_mem;
        flush_hit = if_flush & ~owner_mem_q;
        drop_if   = discard_q | flush_hit;
    end

    assign mem_req_ready = (state_q == IDLE) & grant_mem;
    assign if_req_ready  = (state_q == IDLE) & grant_if;

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        owner_mem_d     = owner_mem_q;
        starve_d        = starve_q;
        tmo_d           = tmo_q;
        discard_d       = discard_q;
        if_rsp_valid_d  = 1'b0;
        if_rsp_inst_d   = if_rsp_inst_q;
        mem_rsp_valid_d = 1'b0;
        mem_rsp_rdata_d = mem_rsp_rdata_q;
        rsp_err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_mem || grant_if) begin
                    state_d     = REQ;
                    owner_mem_d = grant_mem;
                    discard_d   = 1'b0;
                    if (grant_mem) begin
                        req_d = '{addr: mem_addr, wen: mem_wen, wdata: mem_wdata, wmask: mem_wmask};
                        if (if_req_valid && (starve_q != SW'(STARVE_MAX))) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        req_d    = '{addr: if_addr, wen: 1'b0, wdata: '0, wmask: '0};
                        starve_d = '0;
                    end
                end
            end
            REQ: begin
                if (flush_hit) begin
                    discard_d = 1'b1;
                end
                if (bus_req_ready) begin
                    state_d = WAIT_RSP;
                    tmo_d   = '0;
                end
            end
            WAIT_RSP: begin
                tmo_d = tmo_q + TW'(1);
                if (bus_rsp_valid) begin
                    state_d = IDLE;
                    if (owner_mem_q) begin
                        mem_rsp_valid_d = 1'b1;
                        mem_rsp_rdata_d = bus_rsp_rdata;
                    end else if (!drop_if) begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_inst_d  = req_q.addr[2] ? bus_rsp_rdata[63:32] : bus_rsp_rdata[31:0];
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Hung bus: abort and report an error with zeroed data
                    state_d = IDLE;
                    if (owner_mem_q) begin
                        mem_rsp_valid_d = 1'b1;
                        mem_rsp_rdata_d = '0;
                        rsp_err_d       = 1'b1;
                    end else if (!drop_if) begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_inst_d  = '0;
                        rsp_err_d      = 1'b1;
                    end
                end else if (flush_hit) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            discard_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_q           <= '0;
            owner_mem_q     <= 1'b0;
            starve_q        <= '0;
            tmo_q           <= '0;
            discard_q       <= 1'b0;
            bus_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            if_rsp_valid_q  <= 1'b0;
            if_rsp_inst_q   <= '0;
            mem_rsp_valid_q <= 1'b0;
            mem_rsp_rdata_q <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            owner_mem_q     <= owner_mem_d;
            starve_q        <= starve_d;
            tmo_q           <= tmo_d;
            discard_q       <= discard_d;
            bus_req_valid_q <= (state_d == REQ);
            busy_q          <= (state_d != IDLE);
            if_rsp_valid_q  <= if_rsp_valid_d;
            if_rsp_inst_q   <= if_rsp_inst_d;
            mem_rsp_valid_q <= mem_rsp_valid_d;
            mem_rsp_rdata_q <= mem_rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    assign bus_req_valid = bus_req_valid_q;
    assign bus_addr      = req_q.addr;
    assign bus_wen       = req_q.wen;
    assign bus_wdata     = req_q.wdata;
    assign bus_wmask     = req_q.wmask;
    assign busy          = busy_q;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_inst   = if_rsp_inst_q;
    assign mem_rsp_valid = mem_rsp_valid_q;
    assign mem_rsp_rdata = mem_rsp_rdata_q;
    assign rsp_err       = rsp_err_q;

endmodule
